seg7_scan_ctrl: RTL
===================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 The block SHALL have parameter N_DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter BIN_W, default 14, width of value_i, legal range 4..27.
REQ-003 The block SHALL have parameter DIV, default 25000, clk cycles each digit is lit, legal minimum 2.
REQ-004 The block SHALL have port clk  in  1  system clock; all logic on its rising edge; one clock domain.
REQ-005 The block SHALL have port rst_n  in  1  synchronous reset, active-low.
REQ-006 The block SHALL have port load_i  in  1  single-cycle request to capture value_i and hex_i.
REQ-007 The block SHALL have port value_i  in  BIN_W  unsigned binary value to display.
REQ-008 The block SHALL have port hex_i  in  1  1 = show value_i as hex nibbles; 0 = show it as decimal.
REQ-009 The block SHALL have port dp_i  in  N_DIGITS  live decimal-point enables, one bit per digit, not latched.
REQ-010 The block SHALL have port blank_lz_i  in  1  live leading-zero blanking enable.
REQ-011 The block SHALL have port busy_o  out  1  conversion in progress; loads are ignored while high.
REQ-012 The block SHALL have port ovf_o  out  1  last committed decimal value exceeded the display range.
REQ-013 The block SHALL have port an_o  out  N_DIGITS  digit enables, active-low; bit k drives digit k, and digit 0 is the least significant.
REQ-014 The block SHALL have port seg_o  out  8  segments {A,B,C,D,E,F,G,DP} on bits [7:0], active-low; for example, "0" is 0000_0011.

Function
REQ-015 The state machine SHALL have three states, IDLE, CONV and COMMIT; busy_o SHALL be 1 in every state except IDLE.
REQ-016 In IDLE, load_i=1 SHALL capture value_i and hex_i and go to CONV when hex_i=0, or to COMMIT when hex_i=1.
REQ-017 CONV SHALL run a sequential shift-add-3 (double-dabble) conversion, one bit per cycle, for exactly BIN_W cycles, then go to COMMIT.
REQ-018 COMMIT SHALL last 1 cycle, write the N_DIGITS display-digit registers and ovf_o, and return to IDLE.
REQ-019 busy_o SHALL stay high for exactly BIN_W+1 cycles in decimal mode and exactly 1 cycle in hex mode.
REQ-020 In hex mode, digit k SHALL be value_i nibble k, zero-extended; nibbles above N_DIGITS SHALL be discarded, and ovf_o SHALL be 0.
REQ-021 In decimal mode, when value_i >= 10^N_DIGITS, ovf_o SHALL be 1 and every digit SHALL show "-" (seg_o=1111_1101 plus DP).
REQ-022 load_i SHALL be ignored while busy_o=1, including in the COMMIT cycle; the ignored load SHALL NOT be queued.
REQ-023 The display registers SHALL keep the previous digits during CONV, so the display shows no transient.
REQ-024 The scan counter SHALL count 0..DIV-1 and wrap; on each wrap the digit index SHALL advance 0..N_DIGITS-1 and wrap to 0.
REQ-025 an_o and seg_o SHALL be registered, one cycle after the index and counter; exactly one an_o bit SHALL be low at any time after reset.
REQ-026 Glyphs SHALL be 0-9, A, b, C, d, E, F and "-".
REQ-027 The DP segment SHALL be driven low when dp_i[index]=1, independent of blanking and overflow.
REQ-028 When blank_lz_i=1, digit k>0 SHALL be blanked (A..G high) if digits k..N_DIGITS-1 are all zero.
REQ-029 Digit 0 SHALL never be blanked, and blanking SHALL NOT apply while ovf_o=1.
REQ-030 A blanked digit SHALL still have its an_o bit low during its time slot.

Reset
REQ-031 While rst_n=0 at a clock edge, the block SHALL set the state to IDLE, busy_o=0, ovf_o=0, all digits to 0, the counter to 0 and the index to 0.
REQ-032 While rst_n=0 at a clock edge, an_o SHALL be all ones and seg_o SHALL be 8'hFF.
REQ-033 Reset during CONV or COMMIT SHALL abort the operation and SHALL NOT commit a partial result.
REQ-034 In the first cycle after reset release, an_o SHALL stay all ones; in the second cycle, digit 0 SHALL light showing "0".

Structure
REQ-035 A shared package seg7_pkg SHALL hold the state enum, the glyph constants for 0-F, "-" and blank, and the all-off constants for an_o and seg_o.
REQ-036 The double-dabble engine SHALL be a single sub-module seg7_bin2bcd with a start/busy/done interface; the glyph lookup SHALL be a package function.

Verification (N_DIGITS=4, BIN_W=14, DIV=4 unless stated)
REQ-037 Hold rst_n low for 2 cycles -> an_o=1111 and seg_o=FF; after release, an_o cycles 1110, 1101, 1011, 0111 with 4 cycles per digit, and digit 0 shows 0000_0011.
REQ-038 Load 1234 with hex_i=0 -> busy_o high 15 cycles; then digits 3..0 show 1, 2, 3, 4, with digit 0 = 1001_1001; ovf_o=0.
REQ-039 Load 0xBEEF with hex_i=1 and BIN_W=16 -> busy_o high 1 cycle; digit 3 shows b, digits 2..0 show E, E, F.
REQ-040 Load 7 with blank_lz_i=1 and dp_i=0010 -> digit 0 shows 0001_1111; digits 3 and 2 show FF; digit 1 shows 1111_1110 with its an_o bit low.
REQ-041 Load 10000 with hex_i=0 -> ovf_o=1 and all digits show 1111_1101; a following load of 42 clears ovf_o and shows 42.
REQ-042 Load 555, then pulse load_i at busy cycles 3 and 15 -> only 555 is committed; rst_n low at busy cycle 5 -> digits reset to 0 with no commit.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared types and glyph constants for the multiplexed seven-segment scanner.
// Segment bytes are {A,B,C,D,E,F,G,DP}, active-low.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [7:0] SEG_0     = 8'h03;
    localparam logic [7:0] SEG_1     = 8'h9F;
    localparam logic [7:0] SEG_2     = 8'h25;
    localparam logic [7:0] SEG_3     = 8'h0D;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h49;
    localparam logic [7:0] SEG_6     = 8'h41;
    localparam logic [7:0] SEG_7     = 8'h1F;
    localparam logic [7:0] SEG_8     = 8'h01;
    localparam logic [7:0] SEG_9     = 8'h09;
    localparam logic [7:0] SEG_A     = 8'h11;
    localparam logic [7:0] SEG_B     = 8'hC1;
    localparam logic [7:0] SEG_C     = 8'h63;
    localparam logic [7:0] SEG_D     = 8'h85;
    localparam logic [7:0] SEG_E     = 8'h61;
    localparam logic [7:0] SEG_F     = 8'h71;
    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Sized for the widest legal digit count; callers slice to N_DIGITS.
    localparam logic [7:0] AN_OFF  = 8'hFF;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [7:0] glyph(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_bin2bcd.sv
// Sequential double-dabble converter: one shift-add-3 step per cycle for BIN_W cycles.
// bcd_o/ovf_o hold the final result from the cycle after done_o onward.
module seg7_bin2bcd
    import seg7_pkg::*;
#(
    parameter int BIN_W    = 14,
    parameter int N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [BIN_W-1:0]      bin_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [4*N_DIGITS-1:0] bcd_o,
    output logic                  ovf_o
);

    // One spare digit above the largest possible result keeps add-3 from carrying out.
    localparam int FIT_DIGITS = (BIN_W * 3) / 10 + 1;
    localparam int BCD_DIGITS = ((FIT_DIGITS > N_DIGITS) ? FIT_DIGITS : N_DIGITS) + 1;
    localparam int BCD_W      = 4 * BCD_DIGITS;
    localparam int CNT_W      = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] sh_q, sh_d;
    logic [BCD_W-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             unused_adj_msb;

    assign unused_adj_msb = adj[BCD_W-1];

    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end

        sh_d   = sh_q;
        bcd_d  = bcd_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start_i) begin
            sh_d   = bin_i;
            bcd_d  = '0;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            bcd_d = {adj[BCD_W-2:0], sh_q[BIN_W-1]};
            sh_d  = {sh_q[BIN_W-2:0], 1'b0};
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh_q   <= '0;
            bcd_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            sh_q   <= sh_d;
            bcd_q  <= bcd_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign done_o = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
    assign bcd_o  = bcd_q[4*N_DIGITS-1:0];
    assign ovf_o  = |bcd_q[BCD_W-1:4*N_DIGITS];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment display controller: captures a value, converts it to
// hex or decimal digits, and time-slices the digits onto shared active-low segments.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int BIN_W    = 14,
    parameter int DIV      = 25000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [BIN_W-1:0]    value_i,
    input  logic                hex_i,
    input  logic [N_DIGITS-1:0] dp_i,
    input  logic                blank_lz_i,
    output logic                busy_o,
    output logic                ovf_o,
    output logic [N_DIGITS-1:0] an_o,
    output logic [7:0]          seg_o
);

    localparam int DW    = 4 * N_DIGITS;
    localparam int HEX_W = (BIN_W < DW) ? BIN_W : DW;
    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    state_e               state_q, state_d;
    logic [HEX_W-1:0]     hexv_q, hexv_d;
    logic                 hex_q, hex_d;
    logic [DW-1:0]        dig_q, dig_d;
    logic                 ovf_q, ovf_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [N_DIGITS-1:0]  an_q, an_d;
    logic [7:0]           seg_q, seg_d;

    logic                 conv_start, conv_busy, conv_done, conv_ovf;
    logic [DW-1:0]        conv_bcd;

    seg7_bin2bcd #(
        .BIN_W    (BIN_W),
        .N_DIGITS (N_DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (conv_start),
        .bin_i   (value_i),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd),
        .ovf_o   (conv_ovf)
    );

    // Display registers change only in COMMIT, so the old digits stay lit during CONV.
    always_comb begin
        state_d    = state_q;
        hexv_d     = hexv_q;
        hex_d      = hex_q;
        dig_d      = dig_q;
        ovf_d      = ovf_q;
        conv_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    hexv_d     = value_i[HEX_W-1:0];
                    hex_d      = hex_i;
                    conv_start = !hex_i;
                    state_d    = hex_i ? ST_COMMIT : ST_CONV;
                end
            end
            ST_CONV: begin
                if (conv_done) begin
                    state_d = ST_COMMIT;
                end else if (!conv_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                if (hex_q) begin
                    dig_d = DW'(hexv_q);
                    ovf_d = 1'b0;
                end else begin
                    dig_d = conv_bcd;
                    ovf_d = conv_ovf;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic [N_DIGITS-1:0] blank_m;
    logic                all_zero;
    logic [3:0]          sel_dig;
    logic                sel_blank;
    logic                sel_dp;

    always_comb begin
        cnt_d = (cnt_q == CNT_W'(DIV - 1)) ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (cnt_q == CNT_W'(DIV - 1)) begin
            idx_d = (idx_q == IDX_W'(N_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end

        // A digit is a leading zero when it and every digit above it are zero.
        all_zero = 1'b1;
        blank_m  = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            all_zero = all_zero & (dig_q[4*k +: 4] == 4'd0);
            if (k > 0) begin
                blank_m[k] = all_zero;
            end
        end

        sel_dig   = '0;
        sel_blank = 1'b0;
        sel_dp    = 1'b0;
        an_d      = AN_OFF[N_DIGITS-1:0];
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                sel_dig   = dig_q[4*k +: 4];
                sel_blank = blank_m[k];
                sel_dp    = dp_i[k];
                an_d[k]   = 1'b0;
            end
        end

        if (ovf_q) begin
            seg_d = SEG_DASH;
        end else if (blank_lz_i && sel_blank) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = glyph(sel_dig);
        end
        seg_d[0] = !sel_dp;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hexv_q  <= '0;
            hex_q   <= 1'b0;
            dig_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            idx_q   <= '0;
            an_q    <= AN_OFF[N_DIGITS-1:0];
            seg_q   <= SEG_OFF;
        end else begin
            state_q <= state_d;
            hexv_q  <= hexv_d;
            hex_q   <= hex_d;
            dig_q   <= dig_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy_o = (state_q != ST_IDLE);
    assign ovf_o  = ovf_q;
    assign an_o   = an_q;
    assign seg_o  = seg_q;

endmodule
